// File: rtl/seq_shift_unit.sv
// seq_shift_unit
//   Multi-cycle shift/rotate unit. Moves the operand at most STEP bit
//   positions per clock. Handshake is start/ready in, done pulse out.
//
// Parameters
//   N     data width, power of two, >= 2
//   STEP  max positions per clock, power of two, 1 <= STEP <= N
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request, sampled only while ready=1
//   op     000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, others pass a through
//   a      operand, captured on accept
//   b      unsigned shift amount, captured on accept
//   ready  high in IDLE
//   busy   high in SHIFT and DONE
//   done   one-cycle pulse when out is updated
//   out    result register, held until the next done
module seq_shift_unit #(
    parameter int N    = 8,
    parameter int STEP = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] out
);

    localparam int LG = $clog2(N);
    localparam int CW = LG + 1;
    localparam logic [CW-1:0] STEP_C = CW'(STEP);
    localparam logic [CW-1:0] N_C    = CW'(N);

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state;
    logic [N-1:0]    work;
    logic [2:0]      op_q;
    logic [CW-1:0]   remaining;
    logic [CW-1:0]   eff;
    logic [CW-1:0]   k;
    logic [N-1:0]    shifted;

    // One-position move. SRA keeps replicating the current MSB, which is the
    // captured sign bit because the MSB never changes under SRA.
    function automatic logic [N-1:0] step1(input logic [N-1:0] v, input logic [2:0] o);
        case (o)
            OP_SLL:  step1 = {v[N-2:0], 1'b0};
            OP_SRL:  step1 = {1'b0, v[N-1:1]};
            OP_SRA:  step1 = {v[N-1], v[N-1:1]};
            OP_ROL:  step1 = {v[N-2:0], v[N-1]};
            OP_ROR:  step1 = {v[0], v[N-1:1]};
            default: step1 = v;
        endcase
    endfunction

    // Effective amount: shifts saturate at N (any bit above the low LG bits
    // means b >= N), rotates wrap modulo N, reserved ops do nothing.
    always_comb begin
        eff = '0;
        case (op)
            OP_SLL, OP_SRL, OP_SRA: eff = (|b[N-1:LG]) ? N_C : {1'b0, b[LG-1:0]};
            OP_ROL, OP_ROR:         eff = {1'b0, b[LG-1:0]};
            default:                eff = '0;
        endcase
    end

    // Up to STEP single-position moves per clock, gated by what is left.
    always_comb begin
        k       = (remaining < STEP_C) ? remaining : STEP_C;
        shifted = work;
        for (int i = 0; i < STEP; i++) begin
            if (CW'(i) < k) shifted = step1(shifted, op_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            work      <= '0;
            op_q      <= '0;
            remaining <= '0;
            out       <= '0;
            ready     <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        work      <= a;
                        op_q      <= op;
                        remaining <= eff;
                        ready     <= 1'b0;
                        busy      <= 1'b1;
                        if (eff == '0) begin
                            out   <= a;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    work      <= shifted;
                    remaining <= remaining - k;
                    if (remaining == k) begin
                        out   <= shifted;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift_unit.sv
module tb_seq_shift_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_v [2];
    logic [2:0] op = '0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       ready_v [2];
    logic       busy_v  [2];
    logic       done_v  [2];
    logic [7:0] out_v   [2];

    int total = 0;
    int passed = 0;
    int accepts [2];
    int dones   [2];

    always #5 clk = ~clk;

    // instance 0: STEP=1, instance 1: STEP=4
    seq_shift_unit #(.N(8), .STEP(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .op(op), .a(a), .b(b),
        .ready(ready_v[0]), .busy(busy_v[0]), .done(done_v[0]), .out(out_v[0]));
    seq_shift_unit #(.N(8), .STEP(4)) u_s4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .op(op), .a(a), .b(b),
        .ready(ready_v[1]), .busy(busy_v[1]), .done(done_v[1]), .out(out_v[1]));

    always @(negedge clk) begin
        if (rst_n && done_v[0]) dones[0]++;
        if (rst_n && done_v[1]) dones[1]++;
    end

    function automatic int step_of(input int s);
        return (s == 0) ? 1 : 4;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: plain arithmetic on integers.
    function automatic int ref_eff(input int o, input int amt);
        if (o <= 2) return (amt > 8) ? 8 : amt;
        if (o <= 4) return amt % 8;
        return 0;
    endfunction

    function automatic int ref_out(input int o, input int x, input int amt);
        int e, sx;
        e = ref_eff(o, amt);
        sx = (x >= 128) ? x - 256 : x;
        case (o)
            0: return (x << e) & 255;
            1: return (x >> e) & 255;
            2: return (sx >>> e) & 255;
            3: return ((x << e) | (x >> (8 - e))) & 255;
            4: return ((x >> e) | (x << (8 - e))) & 255;
            default: return x;
        endcase
    endfunction

    function automatic int ref_lat(input int o, input int amt, input int st);
        return (ref_eff(o, amt) + st - 1) / st;
    endfunction

    // Run one request on instance s. lat = edges after the accept edge until
    // done is seen. pulse=1 hammers start with junk while busy.
    task automatic run_op(input string name, input int s, input int o, input int x,
                          input int amt, input int exp_out, input int exp_lat,
                          input bit pulse);
        int edges;
        @(negedge clk);
        chk({name, " ready"}, int'(ready_v[s]), 1);
        op = 3'(o); a = 8'(x); b = 8'(amt);
        start_v[s] = 1'b1;
        @(posedge clk);
        accepts[s]++;
        @(negedge clk);
        start_v[s] = pulse;
        op = 3'($urandom_range(0, 7)); a = 8'($urandom); b = 8'($urandom);
        chk({name, " busy"}, int'(ready_v[s]) * 2 + int'(busy_v[s]), 1);
        edges = 0;
        while (!done_v[s] && edges < 20) begin
            @(negedge clk);
            edges++;
            if (pulse) begin a = 8'($urandom); b = 8'($urandom); end
        end
        chk({name, " latency"}, edges, exp_lat);
        chk({name, " out"}, int'(out_v[s]), exp_out);
        @(negedge clk);
        start_v[s] = 1'b0;
        chk({name, " done drop"}, int'(done_v[s]) * 2 + int'(ready_v[s]), 1);
        chk({name, " out hold"}, int'(out_v[s]), exp_out);
    endtask

    typedef struct {
        string name;
        int    s;
        int    o;
        int    x;
        int    amt;
        int    exp_out;
        int    exp_lat;
    } vec_t;

    vec_t vecs [12];

    initial begin
        start_v[0] = 1'b0; start_v[1] = 1'b0;
        accepts[0] = 0; accepts[1] = 0;
        dones[0] = 0; dones[1] = 0;

        vecs[0]  = '{"sll3",    0, 0, 'h96, 3,   'hB0, 3};
        vecs[1]  = '{"sra2",    0, 2, 'h96, 2,   'hE5, 2};
        vecs[2]  = '{"srl2",    0, 1, 'h96, 2,   'h25, 2};
        vecs[3]  = '{"sra200",  0, 2, 'h80, 200, 'hFF, 8};
        vecs[4]  = '{"ror11",   0, 4, 'h96, 11,  'hD2, 3};
        vecs[5]  = '{"rol3s4",  1, 3, 'h96, 3,   'hB4, 1};
        vecs[6]  = '{"zero",    0, 0, 'h5A, 0,   'h5A, 0};
        vecs[7]  = '{"sll9s4",  1, 0, 'hFF, 9,   'h00, 2};
        vecs[8]  = '{"resv",    0, 6, 'h3C, 5,   'h3C, 0};
        vecs[9]  = '{"sra8s4",  1, 2, 'h96, 8,   'hFF, 2};
        vecs[10] = '{"ror7s4",  1, 4, 'h96, 7,   'h2D, 2};
        vecs[11] = '{"srl5s4",  1, 1, 'h96, 5,   'h04, 2};

        // reset state
        #12;
        for (int s = 0; s < 2; s++) begin
            chk("rst ready", int'(ready_v[s]), 1);
            chk("rst busy",  int'(busy_v[s]),  0);
            chk("rst done",  int'(done_v[s]),  0);
            chk("rst out",   int'(out_v[s]),   0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++)
            run_op(vecs[i].name, vecs[i].s, vecs[i].o, vecs[i].x, vecs[i].amt,
                   vecs[i].exp_out, vecs[i].exp_lat, 1'b0);

        // start pulsed with new operands during SHIFT and DONE is ignored
        run_op("pulse", 0, 0, 'h96, 3, 'hB0, 3, 1'b1);
        repeat (3) @(negedge clk);
        chk("idle hold", int'(out_v[0]), 'hB0);
        chk("idle ready", int'(ready_v[0]), 1);

        // asynchronous reset in the middle of an SLL by 6
        @(negedge clk);
        op = 3'd0; a = 8'hC3; b = 8'd6;
        start_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst out",   int'(out_v[0]),   0);
        chk("midrst done",  int'(done_v[0]),  0);
        chk("midrst ready", int'(ready_v[0]), 1);
        chk("midrst busy",  int'(busy_v[0]),  0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("no stale done", dones[0], accepts[0]);
        run_op("post rst", 0, 3, 'h81, 1, 'h03, 1, 1'b0);

        // randomized requests against the reference model
        for (int i = 0; i < 150; i++) begin
            int s, o, x, amt;
            s = int'($urandom_range(0, 1));
            o = int'($urandom_range(0, 7));
            x = int'($urandom_range(0, 255));
            amt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                              : int'($urandom_range(0, 10));
            run_op("rand", s, o, x, amt, ref_out(o, x, amt),
                   ref_lat(o, amt, step_of(s)), 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        chk("done count s1", dones[0], accepts[0]);
        chk("done count s4", dones[1], accepts[1]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
